// File: rtl/hsv_core_commit_order.sv
// Program-order merge point: an order FIFO of unit IDs picks which unit's result goes to commit,
// so results reach commit in issue order even when units finish out of order.
module hsv_core_commit_order #(
  parameter int N_UNITS    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  localparam int ID_W  = $clog2(N_UNITS),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk_core,
  input  logic                          rst_core,
  input  logic                          flush_req,
  output logic                          flush_ack,
  input  logic [ID_W-1:0]               issue_unit,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [N_UNITS*DATA_WIDTH-1:0] unit_data,
  input  logic [N_UNITS-1:0]            unit_valid,
  output logic [N_UNITS-1:0]            unit_ready,
  output logic [DATA_WIDTH-1:0]         commit_data,
  output logic                          commit_valid,
  input  logic                          commit_ready,
  output logic [OCC_W-1:0]              occupancy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // valid never depends on ready; ready may depend on valid-independent state only.

  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0]       fifo_q [DEPTH];
  logic                  commit_valid_q, commit_valid_d;
  logic                  flush_ack_q;
  logic [DATA_WIDTH-1:0] commit_data_q, sel_data;
  logic                  empty, full, out_free, head_rdy, push, accept;
  logic [ID_W-1:0]       head_id;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_id  = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign out_free = ~commit_valid_q | commit_ready;
  assign head_rdy = ~empty & out_free & ~flush_req;

  assign issue_ready = ~full & ~flush_req;
  assign push        = issue_valid & issue_ready;

  // Only the unit named at the FIFO head may hand over its result.
  always_comb begin
    unit_ready = '0;
    sel_data   = '0;
    accept     = 1'b0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (head_id == ID_W'(k)) begin
        unit_ready[k] = head_rdy;
        sel_data      = unit_data[k*DATA_WIDTH +: DATA_WIDTH];
        accept        = unit_valid[k] & head_rdy;
      end
    end
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    commit_valid_d = commit_valid_q;
    if (flush_req) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      commit_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (accept) begin
        rd_ptr_d       = rd_ptr_q + PTR_ONE;
        commit_valid_d = 1'b1;
      end else if (commit_ready) begin
        commit_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      commit_valid_q <= 1'b0;
      flush_ack_q    <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      commit_valid_q <= commit_valid_d;
      flush_ack_q    <= flush_req;
    end
  end

  // Payload and ID storage carry no reset; validity is tracked by the pointers and commit_valid.
  always_ff @(posedge clk_core) begin
    if (push)   fifo_q[wr_ptr_q[PTR_W-1:0]] <= issue_unit;
    if (accept) commit_data_q <= sel_data;
  end

  assign commit_data  = commit_data_q;
  assign commit_valid = commit_valid_q;
  assign flush_ack    = flush_ack_q;
  assign occupancy    = OCC_W'(wr_ptr_q - rd_ptr_q);

  a_issue_unit_legal: assert property (@(posedge clk_core) disable iff (rst_core)
    issue_valid |-> (int'(issue_unit) < N_UNITS));

endmodule

// File: tb/tb_hsv_core_commit_order.sv
// Bench for hsv_core_commit_order: directed scenarios plus a random phase, checked against
// an issue-order queue model and a commit scoreboard.
module tb_hsv_core_commit_order;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int D  = 8;

  logic            clk_core = 1'b0;
  logic            rst_core;
  logic            flush_req;
  logic            flush_ack;
  logic [1:0]      issue_unit;
  logic            issue_valid;
  logic            issue_ready;
  logic [N*DW-1:0] unit_data;
  logic [N-1:0]    unit_valid;
  logic [N-1:0]    unit_ready;
  logic [DW-1:0]   commit_data;
  logic            commit_valid;
  logic            commit_ready;
  logic [3:0]      occupancy;

  hsv_core_commit_order #(.N_UNITS(N), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk_core    (clk_core),
    .rst_core    (rst_core),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .issue_unit  (issue_unit),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .unit_data   (unit_data),
    .unit_valid  (unit_valid),
    .unit_ready  (unit_ready),
    .commit_data (commit_data),
    .commit_valid(commit_valid),
    .commit_ready(commit_ready),
    .occupancy   (occupancy)
  );

  // clock: posedge at 5, 15, ...; inputs change and outputs are sampled in the low phase
  always #5 clk_core = ~clk_core;

  typedef struct {
    int            unit;
    logic [DW-1:0] tok;
  } inst_t;

  inst_t         infl_q[$];   // issued, not yet handed over by its unit, in issue order
  logic [DW-1:0] exp_q[$];    // issued, not yet committed, in issue order
  bit            m_cv;
  bit            m_ack;
  logic [DW-1:0] m_cd;
  logic [DW-1:0] next_tok;
  int            err_n;
  int            chk_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each unit offers the oldest outstanding instruction it owns; idle units drive noise.
  task automatic drive_units(input logic [N-1:0] want);
    for (int k = 0; k < N; k++) begin
      bit found = 0;
      logic [DW-1:0] d = DW'($urandom);
      for (int i = 0; i < infl_q.size(); i++) begin
        if (!found && infl_q[i].unit == k) begin
          found = 1;
          d = infl_q[i].tok;
        end
      end
      unit_valid[k] = want[k] & found;
      unit_data[k*DW +: DW] = d;
    end
  endtask

  task automatic step(input bit iv, input int iu, input logic [N-1:0] want,
                      input bit cr, input bit fl);
    bit           e_ir, acc;
    logic [N-1:0] e_ur;
    issue_valid  = iv;
    issue_unit   = 2'(iu);
    commit_ready = cr;
    flush_req    = fl;
    drive_units(want);
    #1;
    e_ir = (infl_q.size() < D) && !fl;
    e_ur = '0;
    if (infl_q.size() > 0 && (!m_cv || cr) && !fl) e_ur = N'(1 << infl_q[0].unit);
    acc = (e_ur & unit_valid) != '0;
    chk("issue_ready", 32'(issue_ready), 32'(e_ir));
    chk("unit_ready", 32'(unit_ready), 32'(e_ur));
    chk("commit_valid", 32'(commit_valid), 32'(m_cv));
    chk("occupancy", 32'(occupancy), 32'(infl_q.size()));
    chk("flush_ack", 32'(flush_ack), 32'(m_ack));
    if (m_cv) chk("commit_data", 32'(commit_data), 32'(m_cd));
    if (commit_valid === 1'b1 && cr) begin
      if (exp_q.size() > 0) chk("commit_order", 32'(commit_data), 32'(exp_q.pop_front()));
      else chk("commit_spurious", 32'(commit_valid), 32'(0));
    end
    @(posedge clk_core);
    if (fl) begin
      infl_q.delete();
      exp_q.delete();
      m_cv = 0;
    end else begin
      if (acc) begin
        m_cd = infl_q[0].tok;
        void'(infl_q.pop_front());
        m_cv = 1;
      end else if (cr) begin
        m_cv = 0;
      end
      if (iv && e_ir) begin
        infl_q.push_back('{unit: iu, tok: next_tok});
        exp_q.push_back(next_tok);
        next_tok++;
      end
    end
    m_ack = fl;
    @(negedge clk_core);
  endtask

  initial begin
    err_n = 0;
    chk_n = 0;
    next_tok = 16'h0100;
    m_cv = 0;
    m_ack = 1;
    m_cd = '0;
    rst_core = 1;
    flush_req = 0;
    issue_valid = 0;
    issue_unit = 0;
    unit_valid = '0;
    unit_data = '0;
    commit_ready = 0;
    #2;
    chk("reset_occupancy", 32'(occupancy), 32'(0));
    chk("reset_commit_valid", 32'(commit_valid), 32'(0));
    chk("reset_flush_ack", 32'(flush_ack), 32'(1));
    chk("reset_issue_ready", 32'(issue_ready), 32'(1));
    repeat (2) @(negedge clk_core);
    rst_core = 0;

    // in-order stream, each unit valid one cycle after its issue
    step(1, 0, 4'b0000, 1, 0);
    step(1, 1, 4'b0001, 1, 0);
    step(1, 2, 4'b0011, 1, 0);
    step(1, 3, 4'b0111, 1, 0);
    repeat (4) step(0, 0, 4'b1111, 1, 0);
    chk("stream_drained", 32'(occupancy), 32'(0));

    // out-of-order completion: unit 0 done early, must wait behind unit 2
    step(1, 2, 4'b0000, 1, 0);
    step(1, 0, 4'b0000, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'b0001, 1, 0);
    end
    repeat (3) step(0, 0, 4'b0101, 1, 0);

    // fill to full, attempt an extra push, then drain and refill across the wrap
    for (int i = 0; i < D; i++) step(1, $urandom_range(0, 3), 4'b0000, 1, 0);
    chk("full_occupancy", 32'(occupancy), 32'(D));
    step(1, 1, 4'b0000, 1, 0);
    repeat (3) step(1, $urandom_range(0, 3), 4'b1111, 1, 0);
    repeat (12) step(0, 0, 4'b1111, 1, 0);

    // commit backpressure
    repeat (3) step(1, $urandom_range(0, 3), 4'b0000, 1, 0);
    step(0, 0, 4'b1111, 0, 0);
    repeat (4) step(0, 0, 4'b1111, 0, 0);
    repeat (4) step(0, 0, 4'b1111, 1, 0);

    // flush with occupancy 5 and a pending commit
    repeat (6) step(1, $urandom_range(0, 3), 4'b0000, 1, 0);
    step(0, 0, 4'b1111, 0, 0);
    repeat (3) step(1, 1, 4'b1111, 0, 1);
    step(0, 0, 4'b1111, 1, 0);
    step(1, 3, 4'b1111, 1, 0);
    repeat (2) step(0, 0, 4'b1111, 1, 0);

    // asynchronous reset between edges with occupancy 3
    repeat (3) step(1, $urandom_range(0, 3), 4'b0000, 0, 0);
    #2 rst_core = 1;
    #1;
    chk("areset_occupancy", 32'(occupancy), 32'(0));
    chk("areset_commit_valid", 32'(commit_valid), 32'(0));
    chk("areset_flush_ack", 32'(flush_ack), 32'(1));
    infl_q.delete();
    exp_q.delete();
    m_cv = 0;
    m_ack = 1;
    @(negedge clk_core);
    rst_core = 0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), N'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    repeat (20) step(0, 0, 4'b1111, 1, 0);
    chk("final_drained", 32'(occupancy), 32'(0));

    $display("Result: errors=%0d of %0d checks", err_n, chk_n);
    $finish;
  end

endmodule
